// File: rtl/mac_out_drain_if.sv
// Narrow valid/ready beat bus from the MAC output drain to the fabric readout logic.
// The drain drives data/lane/last/valid; the consumer drives ready.
interface mac_out_drain_if #(
    parameter int unsigned DOUT_WIDTH = 8
);
    logic [DOUT_WIDTH-1:0] dout;
    logic [1:0]            dout_lane;
    logic                  dout_last;
    logic                  dout_valid;
    logic                  dout_ready;

    modport master (
        output dout,
        output dout_lane,
        output dout_last,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_lane,
        input  dout_last,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/mac_out_drain.sv
// Snapshot the four MAC cluster accumulators into shadow registers and stream them out
// lane by lane, LSB slice first, over a narrow valid/ready bus.
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif

module mac_out_drain #(
    parameter int unsigned ACC_WIDTH  = `MAC_ACC_WIDTH,
    parameter int unsigned DOUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 snap,
    input  logic [3:0]           lane_mask,
    input  logic [ACC_WIDTH-1:0] acc0,
    input  logic [ACC_WIDTH-1:0] acc1,
    input  logic [ACC_WIDTH-1:0] acc2,
    input  logic [ACC_WIDTH-1:0] acc3,
    mac_out_drain_if.master      dbus,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 clr_overrun
);

    localparam int unsigned BEATS = ACC_WIDTH / DOUT_WIDTH;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);

    if ((BEATS == 0) || ((ACC_WIDTH % DOUT_WIDTH) != 0)) begin : g_bad_width
        $error("ACC_WIDTH must be a nonzero multiple of DOUT_WIDTH");
    end

    typedef enum logic {StIdle, StSend} state_e;

    state_e                state_q;
    logic [ACC_WIDTH-1:0]  shadow_q [4];
    logic [3:0]            mask_q;
    logic [1:0]            lane_q;
    logic [BW-1:0]         beat_q;
    logic [DOUT_WIDTH-1:0] dout_q;
    logic                  last_q;
    logic                  valid_q;
    logic                  overrun_q;

    logic [ACC_WIDTH-1:0]  acc_in [4];
    assign acc_in[0] = acc0;
    assign acc_in[1] = acc1;
    assign acc_in[2] = acc2;
    assign acc_in[3] = acc3;

    function automatic logic [1:0] lowest_lane(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic above_set(input logic [3:0] m, input logic [1:0] lane);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((i > int'(lane)) && m[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [1:0] next_lane(input logic [3:0] m, input logic [1:0] lane);
        logic [1:0] r;
        r = lane;
        for (int i = 3; i >= 0; i--) begin
            if ((i > int'(lane)) && m[i]) r = 2'(i);
        end
        return r;
    endfunction

    logic                  fire;
    logic                  last_hs;
    logic                  snap_req;
    logic                  accept;
    logic                  drop;
    logic [1:0]            first_lane;
    logic                  first_last;
    logic [DOUT_WIDTH-1:0] first_data;
    logic [ACC_WIDTH-1:0]  first_word;
    logic [1:0]            adv_lane;
    logic [BW-1:0]         adv_beat;
    logic                  adv_last;
    logic [ACC_WIDTH-1:0]  adv_word;
    logic [DOUT_WIDTH-1:0] adv_data;

    always_comb begin
        fire       = valid_q && dbus.dout_ready;
        last_hs    = fire && last_q;
        snap_req   = snap && (lane_mask != 4'b0000);
        // A new snapshot may only replace one whose final beat is leaving this cycle.
        accept     = snap_req && ((state_q == StIdle) || last_hs);
        drop       = snap_req && !accept;

        first_lane = lowest_lane(lane_mask);
        first_last = (BEATS == 1) && !above_set(lane_mask, first_lane);
        first_word = acc_in[first_lane];
        first_data = first_word[DOUT_WIDTH-1:0];

        if (beat_q == LastBeat) begin
            adv_lane = next_lane(mask_q, lane_q);
            adv_beat = '0;
        end else begin
            adv_lane = lane_q;
            adv_beat = beat_q + BW'(1);
        end
        adv_last = (adv_beat == LastBeat) && !above_set(mask_q, adv_lane);
        adv_word = shadow_q[adv_lane];
        adv_data = adv_word[int'(adv_beat)*DOUT_WIDTH +: DOUT_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
            mask_q    <= 4'b0000;
            lane_q    <= 2'd0;
            beat_q    <= '0;
            dout_q    <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < 4; i++) shadow_q[i] <= acc_in[i];
                mask_q  <= lane_mask;
                lane_q  <= first_lane;
                beat_q  <= '0;
                dout_q  <= first_data;
                last_q  <= first_last;
                valid_q <= 1'b1;
                state_q <= StSend;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        valid_q <= 1'b0;
                    end
                    StSend: begin
                        if (fire) begin
                            if (last_q) begin
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                state_q <= StIdle;
                            end else begin
                                lane_q <= adv_lane;
                                beat_q <= adv_beat;
                                dout_q <= adv_data;
                                last_q <= adv_last;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end

            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign dbus.dout       = dout_q;
    assign dbus.dout_lane  = lane_q;
    assign dbus.dout_last  = last_q;
    assign dbus.dout_valid = valid_q;
    assign busy            = valid_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_mac_out_drain.sv
// Scoreboard bench for mac_out_drain: stimulus pushes expected beats, a negedge monitor
// pops and compares every accepted beat.
module tb_mac_out_drain;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          snap;
    logic          clr_overrun;
    logic          ready;
    logic          busy;
    logic          overrun;
    logic [3:0]    lane_mask;
    logic [AW-1:0] acc0, acc1, acc2, acc3;

    mac_out_drain_if #(.DOUT_WIDTH(DW)) dbus ();
    assign dbus.dout_ready = ready;

    mac_out_drain #(
        .ACC_WIDTH  (AW),
        .DOUT_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .snap        (snap),
        .lane_mask   (lane_mask),
        .acc0        (acc0),
        .acc1        (acc1),
        .acc2        (acc2),
        .acc3        (acc3),
        .dbus        (dbus),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    lane;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic  pend     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [1:0] l, input logic last);
        beat_t b;
        b.data = d;
        b.lane = l;
        b.last = last;
        sb.push_back(b);
    endtask

    task automatic load_case1();
        acc0 = 32'h1111_2222;
        acc1 = 32'h3333_4444;
        acc2 = 32'h5555_6666;
        acc3 = 32'h7777_8888;
    endtask

    task automatic push_case1();
        push(16'h2222, 2'd0, 1'b0);
        push(16'h1111, 2'd0, 1'b0);
        push(16'h4444, 2'd1, 1'b0);
        push(16'h3333, 2'd1, 1'b0);
        push(16'h6666, 2'd2, 1'b0);
        push(16'h5555, 2'd2, 1'b0);
        push(16'h8888, 2'd3, 1'b0);
        push(16'h7777, 2'd3, 1'b1);
    endtask

    // Called at posedge+1; returns at posedge+1 after the capturing edge.
    task automatic do_snap(input logic [3:0] m);
        snap      = 1'b1;
        lane_mask = m;
        @(posedge clk); #1;
        snap      = 1'b0;
        lane_mask = 4'h0;
    endtask

    task automatic check_drained(input string name);
        check(name, {31'd0, (sb.size() == 0) && !dbus.dout_valid}, 32'd1);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (pend && !rst) check("valid_held", {31'd0, dbus.dout_valid}, 32'd1);
        if (!rst && dbus.dout_valid && ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat: got data %h lane %0d, expected no beat",
                         dbus.dout, dbus.dout_lane);
            end else begin
                e = sb.pop_front();
                check("beat_data", {16'd0, dbus.dout}, {16'd0, e.data});
                check("beat_lane", {30'd0, dbus.dout_lane}, {30'd0, e.lane});
                check("beat_last", {31'd0, dbus.dout_last}, {31'd0, e.last});
            end
        end
        pend = !rst && dbus.dout_valid && !ready;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        rst = 1'b1; snap = 1'b0; clr_overrun = 1'b0; ready = 1'b1; lane_mask = 4'h0;
        acc0 = '0; acc1 = '0; acc2 = '0; acc3 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_dout",    {16'd0, dbus.dout},       32'd0);
        check("rst_lane",    {30'd0, dbus.dout_lane},  32'd0);
        check("rst_last",    {31'd0, dbus.dout_last},  32'd0);
        check("rst_valid",   {31'd0, dbus.dout_valid}, 32'd0);
        check("rst_busy",    {31'd0, busy},            32'd0);
        check("rst_overrun", {31'd0, overrun},         32'd0);

        // Full mask, ready held high: 8 beats in 8 consecutive cycles.
        load_case1();
        push_case1();
        do_snap(4'hF);
        check("s1_latency_valid", {31'd0, dbus.dout_valid}, 32'd1);
        check("s1_busy", {31'd0, busy}, 32'd1);
        repeat (8) begin @(posedge clk); #1; end
        check_drained("s1_no_bubbles");

        // Sparse mask skips lanes 0 and 2 without gaps.
        acc0 = 32'hDEAD_0000; acc1 = 32'hAAAA_BBBB; acc2 = 32'hDEAD_2222; acc3 = 32'hCCCC_DDDD;
        push(16'hBBBB, 2'd1, 1'b0);
        push(16'hAAAA, 2'd1, 1'b0);
        push(16'hDDDD, 2'd3, 1'b0);
        push(16'hCCCC, 2'd3, 1'b1);
        do_snap(4'b1010);
        repeat (4) begin @(posedge clk); #1; end
        check_drained("s2_sparse");

        // Backpressure with ready pattern 1,0,0,1.
        load_case1();
        push_case1();
        do_snap(4'hF);
        pat = 4'b1001;
        for (int i = 0; i < 64 && (sb.size() != 0 || dbus.dout_valid); i++) begin
            ready = pat[i % 4];
            @(posedge clk); #1;
        end
        ready = 1'b1;
        check_drained("s3_backpressure");

        // Overrun on mid-stream snap (set beats clear), then back-to-back on last beat.
        push_case1();
        do_snap(4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("s4_beat3", {16'd0, dbus.dout}, 32'h0000_4444);
        snap = 1'b1; lane_mask = 4'hF; clr_overrun = 1'b1;
        @(posedge clk); #1;
        snap = 1'b0; lane_mask = 4'h0; clr_overrun = 1'b0;
        check("s4_overrun_set", {31'd0, overrun}, 32'd1);
        clr_overrun = 1'b1;
        @(posedge clk); #1;
        clr_overrun = 1'b0;
        check("s4_overrun_clr", {31'd0, overrun}, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("s4_last_beat", {31'd0, dbus.dout_last}, 32'd1);
        acc2 = 32'hDEAD_BEEF;
        push(16'hBEEF, 2'd2, 1'b0);
        push(16'hDEAD, 2'd2, 1'b1);
        do_snap(4'b0100);
        check("s4_b2b_valid", {31'd0, dbus.dout_valid}, 32'd1);
        check("s4_b2b_data",  {16'd0, dbus.dout}, 32'h0000_BEEF);
        check("s4_b2b_no_overrun", {31'd0, overrun}, 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        check_drained("s4_b2b_done");

        // Empty mask is ignored.
        do_snap(4'h0);
        check("s5_valid", {31'd0, dbus.dout_valid}, 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("s5_valid_later", {31'd0, dbus.dout_valid}, 32'd0);
        check("s5_overrun", {31'd0, overrun}, 32'd0);

        // Reset in the middle of a stream, then a clean restart.
        load_case1();
        push_case1();
        do_snap(4'hF);
        repeat (4) begin @(posedge clk); #1; end
        check("s6_beat5", {16'd0, dbus.dout}, 32'h0000_6666);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check("s6_dout",  {16'd0, dbus.dout},       32'd0);
        check("s6_lane",  {30'd0, dbus.dout_lane},  32'd0);
        check("s6_last",  {31'd0, dbus.dout_last},  32'd0);
        check("s6_valid", {31'd0, dbus.dout_valid}, 32'd0);
        check("s6_busy",  {31'd0, busy},            32'd0);
        push_case1();
        do_snap(4'hF);
        check("s6_restart_data", {16'd0, dbus.dout}, 32'h0000_2222);
        repeat (8) begin @(posedge clk); #1; end
        check_drained("s6_restart_done");

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
